load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory-access stage of rv32i_sc. Consumes the ALU effective address (rs1 + sign-extended imm) and rs2 store data.
//  Drives a req/gnt/rvalid data-memory port with byte enables, aligns and sign/zero-extends load data for writeback.
//  Holds the core via stall while an access is outstanding.
// PARAMETERS
//  ADDR_WIDTH  32  effective/memory address width
//  DATA_WIDTH  32  data width; only 32 supported (4 byte lanes)
// PORTS
//  clk          in   1   core clock, all state on rising edge
//  rstn         in   1   asynchronous, active-low reset
//  req_valid    in   1   core presents a load/store this cycle
//  req_ready    out  1   unit in IDLE, can accept a request
//  is_store     in   1   1 = store, 0 = load
//  funct3       in   3   LB/LH/LW/LBU/LHU, SB/SH/SW encodings (rv32i_control.vh)
//  addr         in   32  effective address from ALU results
//  wdata        in   32  store data (rs2)
//  resp_valid   out  1   one-cycle pulse: access complete
//  rdata        out  32  extended load data, valid with resp_valid (0 for stores)
//  stall        out  1   hold PC/pipeline: (req_valid & !resp_valid) | busy
//  misaligned   out  1   only with LSU_MISALIGN_TRAP_EN: one-cycle pulse, request rejected
//  mem_req      out  1   memory request
//  mem_we       out  1   write enable
//  mem_be       out  4   byte enables
//  mem_addr     out  32  word-aligned address {addr[31:2],2'b00}
//  mem_wdata    out  32  store data replicated to lanes
//  mem_gnt      in   1   memory accepted request (same cycle as mem_req)
//  mem_rvalid   in   1   load data valid
//  mem_rdata    in   32  raw word read data
// BEHAVIOUR
//  - Reset: state=IDLE; mem_req, mem_we, resp_valid, misaligned = 0; mem_be = 0; rdata, mem_addr, mem_wdata = 0.
//  - FSM IDLE -> REQ on req_valid (addr/funct3/wdata/is_store registered); REQ holds mem_req=1, outputs stable until mem_gnt.
//  - REQ & mem_gnt & store -> IDLE, resp_valid=1 next cycle. REQ & mem_gnt & load -> WAIT.
//  - WAIT & mem_rvalid -> IDLE, resp_valid=1 with rdata registered. Minimum latency: store 2 cycles, load 3 cycles from req_valid.
//  - mem_gnt and mem_rvalid in the same cycle in REQ: treat as grant only; rvalid is accepted only in WAIT.
//  - Byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
//  - Write data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
//  - Load extract: lane selected by addr[1:0]; LB/LH sign-extend from bit 7/15, LBU/LHU zero-extend, LW passthrough.
//  - Undefined funct3: treated as LW/SW.
//  - req_valid ignored outside IDLE (req_ready=0). rstn low mid-access: immediate return to IDLE, in-flight response dropped.
// CONFIGURATION
//  - LSU_MISALIGN_TRAP_EN defined: half at addr[0]=1 or word at addr[1:0]!=0 is not issued;
//    misaligned and resp_valid pulse together next cycle, rdata=0, state stays IDLE.
//  - LSU_MISALIGN_TRAP_EN undefined: port absent; low address bits ignored for lane selection of wider accesses
//    (half uses addr[1], word uses lane 0); access always issued.
// STRUCTURE
//  - Shared constants (rv32i_params.vh / rv32i_control.vh): INSTR_WIDTH, funct3 load/store encodings, LSU state encodings.
//  - Sub-module: lsu_load_align (combinational lane select + sign/zero extension), instantiated once.
// TESTING
//  - Reset: rstn=0 -> mem_req=0, resp_valid=0, stall=0, req_ready=1.
//  - SW addr=0x1004 wdata=0xDEADBEEF, mem_gnt immediate -> mem_be=1111, mem_addr=0x1004; resp_valid 2 cycles after req.
//  - SB addr=0x1003 wdata=0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5.
//  - LB addr=0x2001, mem_rdata=0x0000_80_00 -> rdata=0xFFFFFF80; LBU same -> rdata=0x00000080.
//  - LH addr=0x2002, mem_rdata=0x8001_0000, gnt delayed 3 cycles, rvalid 2 cycles later -> rdata=0xFFFF8001, stall high throughout.
//  - LW addr=0x3002: with _EN -> misaligned=1, no mem_req; without -> mem_addr=0x3000, rdata=mem_rdata.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 load/store codes, FSM states, access sizes.
// access_size() folds undefined funct3 values into word accesses.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  function automatic lsu_size_t access_size(input logic is_store, input logic [2:0] funct3);
    lsu_size_t sz;
    sz = SZ_W;
    if (is_store) begin
      if (funct3 == F3_B) sz = SZ_B;
      else if (funct3 == F3_H) sz = SZ_H;
    end else begin
      case (funct3)
        F3_B, F3_BU: sz = SZ_B;
        F3_H, F3_HU: sz = SZ_H;
        default:     sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Combinational load alignment: picks the addressed lane of the read word and
// sign/zero-extends it according to the load funct3.
module load_store_unit_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = word >> {lane, 3'b000};

  always_comb begin
    data = word;
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   data = {24'b0, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   data = {16'b0, shifted[15:0]};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: issues one load/store on a req/gnt/rvalid port and stalls the core until done.
// Optional LSU_MISALIGN_TRAP_EN rejects misaligned half/word accesses with a misaligned pulse.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic                  misaligned,
`endif
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_t  state, state_next;
  lsu_size_t   size_in;
  logic [1:0]  lane_in, lane_q;
  logic [3:0]  be_in;
  logic [31:0] wdata_in, load_data;
  logic [2:0]  funct3_q;
  logic        is_store_q, accept, trap_in, issue, trap_acc, store_done, load_done;

  assign size_in = access_size(is_store, funct3);

  always_comb begin
    lane_in  = 2'b00;
    be_in    = 4'b1111;
    wdata_in = wdata;
    case (size_in)
      SZ_B: begin
        lane_in  = addr[1:0];
        be_in    = 4'b0001 << addr[1:0];
        wdata_in = {4{wdata[7:0]}};
      end
      SZ_H: begin
        lane_in  = {addr[1], 1'b0};
        be_in    = 4'b0011 << {addr[1], 1'b0};
        wdata_in = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_in = ((size_in == SZ_H) && addr[0]) || ((size_in == SZ_W) && (addr[1:0] != 2'b00));
`else
  assign trap_in = 1'b0;
`endif

  // The cycle carrying resp_valid still presents the completing instruction, so it must not re-issue.
  assign req_ready = (state == ST_IDLE) && !resp_valid;
  assign accept    = req_valid && req_ready;
  assign issue     = accept && !trap_in;
  assign trap_acc  = accept && trap_in;
  assign stall     = (req_valid && !resp_valid) || (state != ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    store_done = 1'b0;
    load_done  = 1'b0;
    case (state)
      ST_IDLE: if (issue) state_next = ST_REQ;
      ST_REQ: begin
        mem_req = 1'b1;
        mem_we  = is_store_q;
        // A same-cycle rvalid is ignored here; read data is only taken in WAIT.
        if (mem_gnt) begin
          if (is_store_q) begin
            store_done = 1'b1;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: if (mem_rvalid) begin
        load_done  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  load_store_unit_load_align u_align (
    .word   (mem_rdata),
    .lane   (lane_q),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_valid <= 1'b0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_be     <= 4'b0000;
      mem_wdata  <= '0;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      lane_q     <= 2'b00;
    end else begin
      resp_valid <= store_done || load_done || trap_acc;
      rdata      <= load_done ? load_data : '0;
      if (issue) begin
        mem_addr   <= {addr[ADDR_WIDTH-1:2], 2'b00};
        mem_be     <= be_in;
        mem_wdata  <= wdata_in;
        is_store_q <= is_store;
        funct3_q   <= funct3;
        lane_q     <= lane_in;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) misaligned <= 1'b0;
    else       misaligned <= trap_acc;
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: randomized loads/stores against a byte-lane reference model,
// with a memory responder that varies grant/rvalid timing.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0, req_ready, is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0, wdata = '0, rdata, mem_addr, mem_wdata, mem_rdata;
  logic        resp_valid, stall, mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .rdata(rdata), .stall(stall),
`ifdef LSU_MISALIGN_TRAP_EN
    .misaligned(misaligned),
`endif
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } req_exp_t;
  typedef struct { logic [31:0] rdata; int lat; int start; logic mis; } resp_exp_t;
  typedef struct { logic st; int gd; int rg; logic dual; logic [31:0] word; } mem_t;

  req_exp_t  req_q[$];
  resp_exp_t resp_q[$];
  mem_t      mem_q[$];
  int        tests = 0, fails = 0, cyc = 0;
  bit        busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: access width in bytes, lane offset, byte enables, lane data.
  function automatic int model_size(input logic st, input logic [2:0] f3);
    if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input int off, input int sz, input bit sgn);
    logic [31:0] v, mask;
    v    = word >> (8 * off);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v    = v & mask;
    if (sgn && sz < 4 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input int gd, input int rg, input logic dual, input logic [31:0] word);
    int sz, off;
    bit mis, got, sgn;
    logic [31:0] wexp;
    sz   = model_size(st, f3);
    off  = (sz == 1) ? int'(a[1:0]) : (sz == 2) ? 2 * int'(a[1]) : 0;
    mis  = TRAP && ((sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00));
    sgn  = !st && (f3 == 3'd0 || f3 == 3'd1);
    wexp = (sz == 1) ? wd[7:0] * 32'h0101_0101 : (sz == 2) ? wd[15:0] * 32'h0001_0001 : wd;
    @(posedge clk); #1;
    req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd; busy = 1'b1;
    if (!mis) begin
      req_q.push_back('{st, 4'(((1 << sz) - 1) << off), {a[31:2], 2'b00}, wexp});
      mem_q.push_back('{st, gd, rg, dual && !st, word});
    end
    resp_q.push_back('{(st || mis) ? 32'h0 : model_load(word, off, sz, sgn),
                       mis ? 1 : st ? 2 + gd : 2 + gd + rg, cyc, mis});
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
    end
    chk("resp_timeout", {31'b0, got}, 32'd1);
    busy = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  mem_t mm;
  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (rstn && mem_req && mem_q.size() > 0) begin
        mm = mem_q.pop_front();
        repeat (mm.gd) begin @(posedge clk); #1; end
        mem_gnt = 1'b1;
        if (mm.dual) begin mem_rvalid = 1'b1; mem_rdata = ~mm.word; end
        @(posedge clk); #1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if (!mm.st) begin
          repeat (mm.rg - 1) begin @(posedge clk); #1; end
          mem_rvalid = 1'b1; mem_rdata = mm.word;
          @(posedge clk); #1;
          mem_rvalid = 1'b0; mem_rdata = $urandom;
        end
      end
    end
  end

  req_exp_t  me;
  resp_exp_t re;
  always @(negedge clk) begin
    if (rstn) begin
      if (mem_req && mem_gnt) begin
        chk("grant_expected", {31'b0, req_q.size() != 0}, 32'd1);
        if (req_q.size() != 0) begin
          me = req_q.pop_front();
          chk("mem_we", {31'b0, mem_we}, {31'b0, me.we});
          chk("mem_be", {28'b0, mem_be}, {28'b0, me.be});
          chk("mem_addr", mem_addr, me.addr);
          if (me.we) chk("mem_wdata", mem_wdata, me.wdata);
        end
      end
      if (resp_valid) begin
        chk("resp_expected", {31'b0, resp_q.size() != 0}, 32'd1);
        if (resp_q.size() != 0) begin
          re = resp_q.pop_front();
          chk("rdata", rdata, re.rdata);
          chk("latency", cyc - re.start, re.lat);
`ifdef LSU_MISALIGN_TRAP_EN
          chk("misaligned", {31'b0, misaligned}, {31'b0, re.mis});
`endif
        end
        chk("stall_resp", {31'b0, stall}, 32'd0);
      end else if (busy) begin
        chk("stall_busy", {31'b0, stall}, 32'd1);
      end else if (!req_valid) begin
        chk("stall_idle", {31'b0, stall}, 32'd0);
        chk("ready_idle", {31'b0, req_ready}, 32'd1);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    run_txn(1'b1, 3'd2, 32'h0000_1004, 32'hDEAD_BEEF, 0, 1, 1'b0, 32'h0);
    run_txn(1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 1, 1, 1'b0, 32'h0);
    run_txn(1'b0, 3'd0, 32'h0000_2001, 32'h0,         0, 1, 1'b0, 32'h0000_8000);
    run_txn(1'b0, 3'd4, 32'h0000_2001, 32'h0,         0, 1, 1'b0, 32'h0000_8000);
    run_txn(1'b0, 3'd1, 32'h0000_2002, 32'h0,         3, 2, 1'b0, 32'h8001_0000);
    run_txn(1'b0, 3'd2, 32'h0000_3002, 32'h0,         0, 1, 1'b0, 32'h1234_5678);
    run_txn(1'b0, 3'd5, 32'h0000_5002, 32'h0,         1, 2, 1'b1, 32'hC3A5_0F0F);
    run_txn(1'b1, 3'd1, 32'h0000_6002, 32'h1234_BEEF, 2, 1, 1'b0, 32'h0);

    for (int n = 0; n < 200; n++) begin
      logic st;
      st = 1'($urandom % 2);
      run_txn(st, 3'($urandom % 8), $urandom, $urandom, int'($urandom % 4), int'($urandom_range(1, 3)),
              1'(($urandom % 4) == 0), $urandom);
    end

    // Reset while a load is granted-pending: the access must be abandoned.
    @(posedge clk); #1;
    busy = 1'b1; req_valid = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h0000_4000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("midrst_mem_req_before", {31'b0, mem_req}, 32'd1);
    #1; rstn = 1'b0; busy = 1'b0; #1;
    chk("midrst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("midrst_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("req_q_drained", req_q.size(), 32'd0);
    chk("resp_q_drained", resp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
